// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the folded-convolution memory system.
// Used by both the write-side loader and the read-side address controller.
package conv_pkg;

    localparam int FMAP_DIM   = 7;
    localparam int KER_DIM    = 5;
    localparam int FMAP_DEPTH = FMAP_DIM * FMAP_DIM;
    localparam int KER_DEPTH  = KER_DIM * KER_DIM;
    localparam int NUM_KER    = 2;
    localparam int KER1_BASE  = KER_DEPTH;
    localparam int W_DEPTH    = NUM_KER * KER_DEPTH;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_FMAP = 2'd1,
        ST_LOAD_W    = 2'd2,
        ST_DONE      = 2'd3
    } ld_state_t;

    function automatic logic is_load_state(input ld_state_t s);
        return (s == ST_LOAD_FMAP) || (s == ST_LOAD_W);
    endfunction

endpackage

// File: rtl/conv_ram_wr_port.sv
// Registered single-port SRAM write driver: one request cycle becomes one
// cs/we write cycle on the following clock; idle cycles keep cs/we low.
module conv_ram_wr_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cs    <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            cs <= req;
            we <= req;
            // Address and data only move on a real write so the bus stays quiet between beats.
            if (req) begin
                addr  <= req_addr;
                wdata <= req_data;
            end
        end
    end

endmodule

// File: rtl/conv_mem_loader.sv
// Fills the feature-map RAM and then the two-kernel weight RAM from a
// valid/ready byte stream, then raises compute_en for the read side.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready are
// both 1. in_ready is registered and high exactly while loading; the producer
// may drop in_valid on any cycle and the loader simply waits.
module conv_mem_loader #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 6,
    parameter int FMAP_DEPTH = conv_pkg::FMAP_DEPTH,
    parameter int KER_DEPTH  = conv_pkg::KER_DEPTH,
    parameter int NUM_KER    = conv_pkg::NUM_KER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              fmap_cs,
    output logic              fmap_we,
    output logic [ADDR_W-1:0] fmap_addr,
    output logic [DATA_W-1:0] fmap_wdata,
    output logic              w_cs,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_wdata,
    output logic              busy,
    output logic              done,
    output logic              compute_en
);

    import conv_pkg::*;

    localparam logic [ADDR_W-1:0] FMAP_LAST = ADDR_W'(FMAP_DEPTH - 1);
    localparam logic [ADDR_W-1:0] W_LAST    = ADDR_W'(NUM_KER * KER_DEPTH - 1);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              in_ready_q;
    logic              done_q, done_d;
    logic              compute_en_q, compute_en_d;
    logic              beat;
    logic              fmap_req, w_req;

    assign beat = in_valid & in_ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = 1'b0;
        compute_en_d = compute_en_q;
        fmap_req     = 1'b0;
        w_req        = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD_FMAP;
                    cnt_d        = '0;
                    compute_en_d = 1'b0;
                end
            end
            ST_LOAD_FMAP: begin
                if (beat) begin
                    fmap_req = 1'b1;
                    if (cnt_q == FMAP_LAST) begin
                        state_d = ST_LOAD_W;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_W: begin
                if (beat) begin
                    w_req = 1'b1;
                    if (cnt_q == W_LAST) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        compute_en_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // in_ready follows the next state so it drops right after the final weight beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            done_q       <= 1'b0;
            compute_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= is_load_state(state_d);
            done_q       <= done_d;
            compute_en_q <= compute_en_d;
        end
    end

    conv_ram_wr_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fmap_port (
        .clk      (clk),
        .rst      (rst),
        .req      (fmap_req),
        .req_addr (cnt_q),
        .req_data (in_data),
        .cs       (fmap_cs),
        .we       (fmap_we),
        .addr     (fmap_addr),
        .wdata    (fmap_wdata)
    );

    // The weight counter runs straight through both kernels, so kernel 1 lands at KER_DEPTH.
    conv_ram_wr_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_w_port (
        .clk      (clk),
        .rst      (rst),
        .req      (w_req),
        .req_addr (cnt_q),
        .req_data (in_data),
        .cs       (w_cs),
        .we       (w_we),
        .addr     (w_addr),
        .wdata    (w_wdata)
    );

    assign in_ready   = in_ready_q;
    assign busy       = is_load_state(state_q);
    assign done       = done_q;
    assign compute_en = compute_en_q;

endmodule

// File: doc/conv_mem_loader.md
Name: conv_mem_loader

Overview:
- Write-side companion to the folded-convolution address controller.
- Accepts a valid/ready byte stream and fills two single-port SRAMs:
  - the 7x7 feature-map RAM, at addresses 0..48 in raster order;
  - the weight RAM, holding two 5x5 kernels: kernel 0 at 0..24, kernel 1 at 25..49, matching the weight_select offset of 25.
- After the last write it releases the compute side by asserting compute_en, which gates the read-side controller.

Parameters:
- DATA_W, 8, width of stream and SRAM data words.
- ADDR_W, 6, SRAM address width.
- FMAP_DEPTH, 49, feature-map words per load (7x7).
- KER_DEPTH, 25, words per kernel (5x5).
- NUM_KER, 2, kernels loaded after the feature map.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle load request; honoured only in IDLE or DONE.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_W  stream word.
- in_ready  out  1  loader can accept a word this cycle.
- fmap_cs  out  1  feature-map RAM chip select.
- fmap_we  out  1  feature-map RAM write enable.
- fmap_addr  out  ADDR_W  feature-map RAM address.
- fmap_wdata  out  DATA_W  feature-map RAM write data.
- w_cs  out  1  weight RAM chip select.
- w_we  out  1  weight RAM write enable.
- w_addr  out  ADDR_W  weight RAM address.
- w_wdata  out  DATA_W  weight RAM write data.
- busy  out  1  high while in LOAD_FMAP or LOAD_W.
- done  out  1  one-cycle pulse on entry to DONE.
- compute_en  out  1  high from DONE entry until the next accepted start or rst.

Behaviour:
- Reset:
  - rst high at a clock edge forces IDLE.
  - All outputs go to 0, including in_ready, cs/we, addresses, wdata, busy, done and compute_en.
  - Reset mid-load aborts the load; RAM contents are then undefined; no further writes are issued.
- States: IDLE, LOAD_FMAP, LOAD_W, DONE.
  - IDLE -> LOAD_FMAP on start. Word counter := 0; compute_en := 0.
  - LOAD_FMAP -> LOAD_W on the handshake of word FMAP_DEPTH-1 (48). Counter := 0.
  - LOAD_W -> DONE on the handshake of word NUM_KER*KER_DEPTH-1 (49). done pulses 1 cycle; compute_en := 1.
  - DONE -> LOAD_FMAP on start; otherwise DONE is held.
- start while busy is ignored; there is no restart or queueing.
- Handshake:
  - A beat transfers when in_valid & in_ready at the clock edge.
  - in_ready is registered and equals 1 in LOAD_FMAP and LOAD_W.
  - in_ready drops in the cycle after the final beat of LOAD_W.
  - in_valid outside the load states is ignored and no write occurs.
  - Stalls (in_valid low) may occur on any cycle; the counter holds and no write occurs.
- Write timing:
  - All SRAM outputs are registered.
  - A beat accepted at edge N produces cs=we=1, addr and wdata in the cycle after edge N.
  - cs/we return to 0 in any cycle that has no accepted beat on the preceding edge.
  - Only one RAM is written per cycle: beats in LOAD_FMAP drive fmap_*, beats in LOAD_W drive w_*.
- Addressing:
  - The feature-map address equals the word counter, 0..48.
  - The weight address equals the counter, 0..49; the kernel k base is k*KER_DEPTH.
  - The counter is ADDR_W bits and never wraps within a load; it resets to 0 at each phase change.
- Back-to-back: the final feature-map beat and the first weight beat may arrive on consecutive cycles with no bubble.
- The final write of a load is visible on w_* in the same cycle that done is 1.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum;
  - FMAP_DIM=7, KER_DIM=5, FMAP_DEPTH, KER_DEPTH, NUM_KER and KER1_BASE=25, all also used by the read-side controller.
- One natural sub-module, conv_ram_wr_port: a registered cs/we/addr/wdata driver, instantiated once per RAM.

Test Plan:
- Full load with in_valid held high, data = index (0..98) -> fmap writes addr 0..48 carry data 0..48, then weight writes addr 0..49 carry data 49..98. done pulses exactly once; compute_en = 1 from that cycle. Total = 100 cycles from start to done.
- Random in_valid stalls (~50% duty) -> identical address/data sequence to the first test; no cs/we in stall cycles; counter never skips.
- start pulsed at word 20 of LOAD_FMAP -> ignored: addresses continue 21..48, then the weight phase follows normally.
- rst asserted during weight word 10 -> next cycle all outputs 0 and state IDLE. With no new start, 10 further in_valid cycles produce no writes.
- Second start from DONE -> compute_en drops the next cycle, fmap_addr restarts at 0, and the full sequence repeats.
- in_valid high in IDLE for 5 cycles before start -> in_ready stays 0, no writes; the first write after start is fmap_addr 0.
